lock_entry_sequencer: RTL

- Sequences the digital lock's user flow around its passcode datapath: keypad edge detection, digit assembly, set-and-confirm on lock, compare on unlock.
- Adds a failed-attempt counter with timed lockout and an inactivity timeout that discards partial entries.
- Sits between the raw keypad inputs and the lock actuator/display outputs.

---
 rtl/lock_pkg.sv | 24 ++
 rtl/key_press_detect.sv | 22 ++
 rtl/lock_entry_sequencer.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/lock_pkg.sv
// Shared encodings and constants for the keypad lock sequencer.
package lock_pkg;

  typedef enum logic [2:0] {
    UNLOCK_READ1 = 3'd0,
    UNLOCK_READ2 = 3'd1,
    UNLOCK_CHECK = 3'd2,
    LOCK_READ    = 3'd3,
    LOCK_CHECK   = 3'd4,
    LOCKOUT      = 3'd5
  } lock_state_e;

  localparam logic [3:0] KEY_NONE = 4'h0;

  // Factory code: all ones in the low 'width' bits.
  function automatic logic [63:0] default_passcode(input int width);
    logic [63:0] code;
    code = '0;
    for (int i = 0; i < 64; i++)
      if (i < width) code[i] = 1'b1;
    return code;
  endfunction

endpackage

// File: rtl/key_press_detect.sv
// Keypad edge detector: one strobe per key-down, a held or changed key is not a new press.
module key_press_detect
  import lock_pkg::*;
(
  input  logic       clock,
  input  logic       reset,
  input  logic [3:0] key,
  output logic       press,
  output logic [3:0] digit
);

  logic [3:0] key_prev;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) key_prev <= KEY_NONE;
    else        key_prev <= key;
  end

  assign press = (key != KEY_NONE) && (key_prev == KEY_NONE);
  assign digit = key;

endmodule

// File: rtl/lock_entry_sequencer.sv
// Keypad lock user flow: set-and-confirm to lock, compare to unlock,
// failed-attempt lockout and inactivity discard of partial entries.
module lock_entry_sequencer
  import lock_pkg::*;
#(
  parameter int PASSCODE_LENGTH = 4,
  parameter int PASSCODE_WIDTH  = 4*PASSCODE_LENGTH,
  parameter int MAX_ATTEMPTS    = 3,
  parameter int LOCKOUT_CYCLES  = 50000000,
  parameter int TIMEOUT_CYCLES  = 250000000
) (
  input  logic                                 clock,
  input  logic                                 reset,
  input  logic [3:0]                           key,
  output logic                                 locked,
  output logic                                 lockout,
  output logic                                 error,
  output logic [$clog2(PASSCODE_LENGTH+1)-1:0] digit_count,
  output logic [2:0]                           state
);

  localparam int CW = $clog2(PASSCODE_LENGTH+1);
  localparam int FW = $clog2(MAX_ATTEMPTS+1);
  localparam int LW = $clog2(LOCKOUT_CYCLES+1);
  localparam int TW = $clog2(TIMEOUT_CYCLES+1);
  localparam logic [CW-1:0]             FULL         = CW'(PASSCODE_LENGTH);
  localparam logic [FW-1:0]             MAX_FAIL     = FW'(MAX_ATTEMPTS);
  localparam logic [PASSCODE_WIDTH-1:0] DEFAULT_CODE = PASSCODE_WIDTH'(default_passcode(PASSCODE_WIDTH));

  logic       press;
  logic [3:0] digit;

  key_press_detect u_kpd (
    .clock (clock),
    .reset (reset),
    .key   (key),
    .press (press),
    .digit (digit)
  );

  lock_state_e               state_q, state_d;
  logic [PASSCODE_WIDTH-1:0] entry1_q, entry1_d, entry2_q, entry2_d, stored_q, stored_d;
  logic [CW-1:0]             count_q, count_d, count_inc;
  logic [FW-1:0]             fail_q, fail_d, fail_inc;
  logic [TW-1:0]             idle_q, idle_d;
  logic [LW-1:0]             lock_tmr_q, lock_tmr_d;
  logic                      locked_q, locked_d, lockout_q, lockout_d, error_q, error_d;
  logic                      reading, idle_run;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q    <= UNLOCK_READ1;
      entry1_q   <= '0;
      entry2_q   <= '0;
      stored_q   <= DEFAULT_CODE;
      count_q    <= '0;
      fail_q     <= '0;
      idle_q     <= '0;
      lock_tmr_q <= '0;
      locked_q   <= 1'b0;
      lockout_q  <= 1'b0;
      error_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      entry1_q   <= entry1_d;
      entry2_q   <= entry2_d;
      stored_q   <= stored_d;
      count_q    <= count_d;
      fail_q     <= fail_d;
      idle_q     <= idle_d;
      lock_tmr_q <= lock_tmr_d;
      locked_q   <= locked_d;
      lockout_q  <= lockout_d;
      error_q    <= error_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    entry1_d   = entry1_q;
    entry2_d   = entry2_q;
    stored_d   = stored_q;
    count_d    = count_q;
    fail_d     = fail_q;
    idle_d     = idle_q;
    lock_tmr_d = lock_tmr_q;
    locked_d   = locked_q;
    lockout_d  = lockout_q;
    error_d    = 1'b0;

    reading   = (state_q == UNLOCK_READ1) || (state_q == UNLOCK_READ2) || (state_q == LOCK_READ);
    idle_run  = reading && ((state_q == UNLOCK_READ2) || (count_q != '0));
    count_inc = count_q + 1'b1;
    fail_inc  = (fail_q < MAX_FAIL) ? fail_q + 1'b1 : fail_q;

    // A press in the expiry cycle takes priority and reloads the idle timer.
    if (reading && press) begin
      idle_d  = TW'(TIMEOUT_CYCLES);
      count_d = count_inc;
      if (state_q == UNLOCK_READ2) entry2_d = (entry2_q << 4) | PASSCODE_WIDTH'(digit);
      else                         entry1_d = (entry1_q << 4) | PASSCODE_WIDTH'(digit);
      if (count_inc == FULL) begin
        case (state_q)
          UNLOCK_READ1: begin
            state_d = UNLOCK_READ2;
            count_d = '0;
          end
          UNLOCK_READ2: state_d = UNLOCK_CHECK;
          default:      state_d = LOCK_CHECK;
        endcase
      end
    end else if (idle_run) begin
      if (idle_q <= TW'(1)) begin
        entry1_d = '0;
        entry2_d = '0;
        count_d  = '0;
        state_d  = (state_q == LOCK_READ) ? LOCK_READ : UNLOCK_READ1;
      end else begin
        idle_d = idle_q - 1'b1;
      end
    end

    case (state_q)
      UNLOCK_CHECK: begin
        entry1_d = '0;
        entry2_d = '0;
        count_d  = '0;
        if (entry1_q == entry2_q) begin
          stored_d = entry1_q;
          locked_d = 1'b1;
          state_d  = LOCK_READ;
        end else begin
          error_d = 1'b1;
          state_d = UNLOCK_READ1;
        end
      end
      LOCK_CHECK: begin
        entry1_d = '0;
        entry2_d = '0;
        count_d  = '0;
        if (entry1_q == stored_q) begin
          locked_d = 1'b0;
          fail_d   = '0;
          state_d  = UNLOCK_READ1;
        end else begin
          error_d = 1'b1;
          fail_d  = fail_inc;
          if (fail_inc == MAX_FAIL) begin
            lockout_d  = 1'b1;
            lock_tmr_d = LW'(LOCKOUT_CYCLES);
            state_d    = LOCKOUT;
          end else begin
            state_d = LOCK_READ;
          end
        end
      end
      LOCKOUT: begin
        if (lock_tmr_q <= LW'(1)) begin
          lockout_d = 1'b0;
          fail_d    = '0;
          state_d   = LOCK_READ;
        end else begin
          lock_tmr_d = lock_tmr_q - 1'b1;
        end
      end
      default: ;
    endcase
  end

  assign locked      = locked_q;
  assign lockout     = lockout_q;
  assign error       = error_q;
  assign digit_count = count_q;
  assign state       = state_q;

endmodule
